bp_fe_bp_tracker: RTL and testbench
===================================

BP_FE_BP_TRACKER -- requirements
Module: bp_fe_bp_tracker

Interface
REQ-001 The module SHALL have parameter bht_idx_width_p, default "inv", meaning the BHT index width; it must be overridden.
REQ-002 The module SHALL have parameter els_p, default 8, meaning the tracking queue depth; it must be a power of 2 and at least 2.
REQ-003 The module SHALL have parameter cnt_width_p, default 16, meaning the mispredict counter width.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port fetch_v_i, input, 1 bit: a fetched branch requests a prediction.
REQ-007 The module SHALL have port fetch_idx_i, input, bht_idx_width_p bits: the BHT index of the fetched branch.
REQ-008 The module SHALL have port fetch_ready_o, output, 1 bit: the queue can accept an entry this cycle.
REQ-009 The module SHALL have port r_v_o, output, 1 bit: predictor read valid.
REQ-010 The module SHALL have port idx_r_o, output, bht_idx_width_p bits: predictor read index.
REQ-011 The module SHALL have port predict_i, input, 1 bit: same-cycle prediction from the predictor (1 = taken).
REQ-012 The module SHALL have port fetch_pred_o, output, 1 bit: the prediction forwarded to fetch.
REQ-013 The module SHALL have port res_v_i, input, 1 bit: the backend resolves the oldest tracked branch.
REQ-014 The module SHALL have port res_taken_i, input, 1 bit: the actual branch outcome.
REQ-015 The module SHALL have port res_ready_o, output, 1 bit: at least one entry is tracked.
REQ-016 The module SHALL have port flush_i, input, 1 bit: squash all tracked entries.
REQ-017 The module SHALL have port w_v_o, output, 1 bit: predictor update valid.
REQ-018 The module SHALL have port idx_w_o, output, bht_idx_width_p bits: predictor update index.
REQ-019 The module SHALL have port correct_o, output, 1 bit: the prediction was correct.
REQ-020 The module SHALL have port mispredict_cnt_o, output, cnt_width_p bits: saturating count of mispredictions.

Function
REQ-021 r_v_o SHALL equal fetch_v_i & fetch_ready_o & ~flush_i, combinationally.
REQ-022 idx_r_o SHALL equal fetch_idx_i, and fetch_pred_o SHALL equal predict_i, both combinationally.
REQ-023 Enqueue SHALL occur on a clock edge when r_v_o=1; it writes {fetch_idx_i, predict_i} at the tail and the tail pointer increments modulo els_p.
REQ-024 fetch_ready_o SHALL equal (count != els_p); a dequeue in the same cycle SHALL NOT make room for an enqueue when the queue is full.
REQ-025 res_ready_o SHALL equal (count != 0).
REQ-026 Dequeue SHALL occur when res_v_i & res_ready_o; the head entry is popped and the head pointer increments modulo els_p.
REQ-027 The update SHALL be registered, with latency 1: on the edge after a dequeue, w_v_o=1, idx_w_o=head idx, and correct_o=(head pred == res_taken_i).
REQ-028 w_v_o SHALL be 1 for exactly one cycle per dequeue.
REQ-029 idx_w_o and correct_o SHALL hold their last value when w_v_o=0.
REQ-030 A dequeue with head pred != res_taken_i SHALL increment mispredict_cnt_o on the same edge that w_v_o rises; the counter saturates at all-ones.
REQ-031 res_v_i while res_ready_o=0 SHALL be ignored: no update, no counter change.
REQ-032 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-033 flush_i=1 SHALL set count, head and tail to 0 on the next edge and SHALL block enqueue that cycle.
REQ-034 A dequeue in the same cycle as flush_i SHALL still complete and emit its update and counter change.
REQ-035 Count SHALL be log2(els_p)+1 bits wide; pointers SHALL be log2(els_p) bits wide and wrap naturally.

Reset
REQ-036 While reset_i=1, asynchronously: count=0, head=0, tail=0, w_v_o=0, idx_w_o=0, correct_o=0, mispredict_cnt_o=0.
REQ-037 Consequently, during reset fetch_ready_o=1 and res_ready_o=0.
REQ-038 Reset asserted mid-operation SHALL discard all entries and any pending update.
REQ-039 Queue storage contents need not be reset.

Verification
REQ-040 Scenario 1: reset, then fetch idx 5 with predict 1, then resolve with taken 0 -> next cycle w_v_o=1, idx_w_o=5, correct_o=0, and mispredict_cnt_o=1.
REQ-041 Scenario 2: fill 8 entries with idx 0..7 -> fetch_ready_o=0; a fetch while full -> r_v_o=0 and no enqueue; 8 resolves -> idx_w_o sequence 0..7 and res_ready_o=0 at the end.
REQ-042 Scenario 3: fill 8 entries, drain 3, enqueue 3 -> tail wraps and the resolve order stays FIFO.
REQ-043 Scenario 4: 4 entries queued, flush_i together with res_v_i -> one update is emitted for the head, count=0 next cycle, and a fetch in the flush cycle is not enqueued.
REQ-044 Scenario 5: res_v_i on an empty queue -> w_v_o stays 0 and mispredict_cnt_o is unchanged.
REQ-045 Scenario 6: with cnt_width_p=2, 5 mispredicts -> mispredict_cnt_o=3; assert reset_i mid-stream -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_fe_bp_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_bp_tracker                                                         |
// | FIFO of in-flight branch predictions; retires them against resolved      |
// | outcomes to drive predictor updates and a saturating mispredict count.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bp_fe_bp_tracker #(
  parameter bht_idx_width_p = "inv",
  parameter int els_p = 8,
  parameter int cnt_width_p = 16,
  // An unconfigured index width collapses to 1 bit so the block still elaborates
  localparam int c_idx_w = (int'(bht_idx_width_p) >= 1 && int'(bht_idx_width_p) <= 1024)
                           ? int'(bht_idx_width_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   fetch_v_i,
  input  logic [c_idx_w-1:0]     fetch_idx_i,
  output logic                   fetch_ready_o,
  output logic                   r_v_o,
  output logic [c_idx_w-1:0]     idx_r_o,
  input  logic                   predict_i,
  output logic                   fetch_pred_o,
  input  logic                   res_v_i,
  input  logic                   res_taken_i,
  output logic                   res_ready_o,
  input  logic                   flush_i,
  output logic                   w_v_o,
  output logic [c_idx_w-1:0]     idx_w_o,
  output logic                   correct_o,
  output logic [cnt_width_p-1:0] mispredict_cnt_o
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_idx_w-1:0] r_idx_mem [els_p];
  logic [els_p-1:0]   r_pred_mem;

  logic w_enq;
  logic w_deq;
  logic w_correct;

  assign fetch_ready_o = (r_count != c_cnt_w'(els_p));
  assign res_ready_o   = (r_count != '0);
  assign r_v_o         = fetch_v_i & fetch_ready_o & ~flush_i;
  assign idx_r_o       = fetch_idx_i;
  assign fetch_pred_o  = predict_i;

  assign w_enq     = r_v_o;
  assign w_deq     = res_v_i & res_ready_o;
  assign w_correct = (r_pred_mem[r_head] == res_taken_i);

  // Storage is qualified by the pointers, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_idx_mem[r_tail]  <= fetch_idx_i;
      r_pred_mem[r_tail] <= predict_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush_i) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + c_ptr_w'(1);
      if (w_deq) r_head <= r_head + c_ptr_w'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A dequeue alongside a flush still retires the head entry
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_o            <= 1'b0;
      idx_w_o          <= '0;
      correct_o        <= 1'b0;
      mispredict_cnt_o <= '0;
    end else begin
      w_v_o <= w_deq;
      if (w_deq) begin
        idx_w_o   <= r_idx_mem[r_head];
        correct_o <= w_correct;
        if (!w_correct && !(&mispredict_cnt_o))
          mispredict_cnt_o <= mispredict_cnt_o + cnt_width_p'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_bp_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_fe_bp_tracker                                                      |
// | Randomized and directed scoreboard bench for bp_fe_bp_tracker.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bp_fe_bp_tracker;

  localparam int IDXW = 6;
  localparam int ELS  = 8;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct packed {logic [IDXW-1:0] idx; logic pred;} ent_t;
  typedef struct packed {logic [IDXW-1:0] idx; logic correct;} exp_t;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            fetch_v_i = 1'b0;
  logic [IDXW-1:0] fetch_idx_i = '0;
  logic            fetch_ready_o;
  logic            r_v_o;
  logic [IDXW-1:0] idx_r_o;
  logic            predict_i = 1'b0;
  logic            fetch_pred_o;
  logic            res_v_i = 1'b0;
  logic            res_taken_i = 1'b0;
  logic            res_ready_o;
  logic            flush_i = 1'b0;
  logic            w_v_o;
  logic [IDXW-1:0] idx_w_o;
  logic            correct_o;
  logic [CNTW-1:0] mispredict_cnt_o;

  bp_fe_bp_tracker #(.bht_idx_width_p(IDXW), .els_p(ELS), .cnt_width_p(CNTW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i), .fetch_ready_o(fetch_ready_o),
    .r_v_o(r_v_o), .idx_r_o(idx_r_o), .predict_i(predict_i), .fetch_pred_o(fetch_pred_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready_o),
    .flush_i(flush_i), .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ent_t            model_q [$];
  exp_t            exp_q   [$];
  int              mcnt = 0;
  logic [IDXW-1:0] last_idx = '0;
  logic            last_corr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Registered-output monitor: each retired entry must appear exactly one edge later
  always @(negedge clk) begin
    if (!reset_i) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("w_v_pulse", 32'(w_v_o), 32'd1);
        chk("idx_w", 32'(idx_w_o), 32'(e.idx));
        chk("correct", 32'(correct_o), 32'(e.correct));
        last_idx  = e.idx;
        last_corr = e.correct;
      end else begin
        chk("w_v_idle", 32'(w_v_o), 32'd0);
        chk("idx_w_hold", 32'(idx_w_o), 32'(last_idx));
        chk("correct_hold", 32'(correct_o), 32'(last_corr));
      end
      chk("mispredict_cnt", 32'(mispredict_cnt_o), 32'(mcnt));
    end
  end

  // Drive one cycle from just after a falling edge; advance the model at the rising edge
  task automatic cycle(input logic fv, input logic [IDXW-1:0] fidx, input logic pred,
                       input logic rv, input logic taken, input logic fl);
    bit exp_enq, exp_deq;
    fetch_v_i = fv; fetch_idx_i = fidx; predict_i = pred;
    res_v_i = rv; res_taken_i = taken; flush_i = fl;
    #1;
    exp_enq = fv && (model_q.size() < ELS) && !fl;
    exp_deq = rv && (model_q.size() > 0);
    chk("fetch_ready", 32'(fetch_ready_o), 32'(model_q.size() < ELS));
    chk("res_ready", 32'(res_ready_o), 32'(model_q.size() > 0));
    chk("r_v", 32'(r_v_o), 32'(exp_enq));
    chk("idx_r", 32'(idx_r_o), 32'(fidx));
    chk("fetch_pred", 32'(fetch_pred_o), 32'(pred));
    if (exp_deq) begin
      ent_t h;
      h = model_q.pop_front();
      if (h.pred != taken && mcnt < CMAX) mcnt++;
      exp_q.push_back('{idx: h.idx, correct: (h.pred == taken)});
    end
    if (fl) model_q.delete();
    else if (exp_enq) model_q.push_back('{idx: fidx, pred: pred});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset lands mid low-phase; outputs must clear before any clock edge
  task automatic do_reset();
    fetch_v_i = 1'b0; res_v_i = 1'b0; flush_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_w_v", 32'(w_v_o), 32'd0);
    chk("rst_idx_w", 32'(idx_w_o), 32'd0);
    chk("rst_correct", 32'(correct_o), 32'd0);
    chk("rst_cnt", 32'(mispredict_cnt_o), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_res_ready", 32'(res_ready_o), 32'd0);
    model_q.delete();
    exp_q.delete();
    mcnt = 0; last_idx = '0; last_corr = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // single mispredicted branch
    cycle(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // fill, blocked fetch when full, drain in order
    do_reset();
    for (int i = 0; i < ELS; i++) cycle(1'b1, IDXW'(i), 1'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'd33, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ELS - 1; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    idle();

    // pointer wrap
    do_reset();
    for (int i = 0; i < ELS; i++) cycle(1'b1, IDXW'(i + 10), 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, IDXW'(i + 40), 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ELS; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    idle();

    // flush together with resolve and fetch
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, IDXW'(i + 20), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'd63, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    idle();

    // resolve on empty queue
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // saturation, then asynchronous reset with live outputs
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, IDXW'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 32'(mispredict_cnt_o), 32'(CMAX));
    cycle(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), IDXW'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 19) == 0));
      if (i == 200) do_reset();
    end
    idle();
    idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
